i2c_poll_scheduler: RTL and testbench

//  Periodic sequencer for the shared byte-level I2C master. Each poll period it issues
//  a fixed register-read transaction: START, addr+W, reg, rSTART, addr+R, MSB, LSB, STOP.
//  It assembles the 16-bit result and holds it on data for the 7-segment display path.
//  On NACK it retries the whole transaction, then flags an error.

---
 rtl/i2c_poll_scheduler_pkg.sv | 58 +++++
 rtl/i2c_poll_scheduler_poll_timer.sv | 36 +++
 rtl/i2c_poll_scheduler.sv | 172 +++++++++++++++++
 tb/tb_i2c_poll_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_poll_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// i2c_poll_scheduler_pkg
// Shared definitions for the I2C poll scheduler and the byte-level I2C engine.
//   I2C_OP_*       3-bit command opcodes understood by the byte engine
//   state_t        scheduler FSM states, one per command of the read transaction
//   cmd_t          opcode + write byte issued in a given state
//   cmd_for_state  maps a state to the command it issues
// -----------------------------------------------------------------------------
package i2c_poll_scheduler_pkg;

   localparam logic [2:0] I2C_OP_START     = 3'd0;
   localparam logic [2:0] I2C_OP_RSTART    = 3'd1;
   localparam logic [2:0] I2C_OP_WRITE     = 3'd2;
   localparam logic [2:0] I2C_OP_READ_ACK  = 3'd3;
   localparam logic [2:0] I2C_OP_READ_NACK = 3'd4;
   localparam logic [2:0] I2C_OP_STOP      = 3'd5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR_W,
      ST_REG,
      ST_RSTART,
      ST_ADDR_R,
      ST_READ_MSB,
      ST_READ_LSB,
      ST_STOP,
      ST_STOP_ERR
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] wdata;
   } cmd_t;

   // Non-WRITE commands always carry a zero data byte.
   function automatic cmd_t cmd_for_state(input state_t s,
                                          input logic [6:0] dev_addr,
                                          input logic [7:0] reg_addr);
      cmd_t c;
      c.op    = I2C_OP_START;
      c.wdata = 8'h00;
      case (s)
         ST_START:    c.op = I2C_OP_START;
         ST_ADDR_W:   begin c.op = I2C_OP_WRITE; c.wdata = {dev_addr, 1'b0}; end
         ST_REG:      begin c.op = I2C_OP_WRITE; c.wdata = reg_addr;          end
         ST_RSTART:   c.op = I2C_OP_RSTART;
         ST_ADDR_R:   begin c.op = I2C_OP_WRITE; c.wdata = {dev_addr, 1'b1}; end
         ST_READ_MSB: c.op = I2C_OP_READ_ACK;
         ST_READ_LSB: c.op = I2C_OP_READ_NACK;
         ST_STOP:     c.op = I2C_OP_STOP;
         ST_STOP_ERR: c.op = I2C_OP_STOP;
         default:     c.op = I2C_OP_START;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/i2c_poll_scheduler_poll_timer.sv
// -----------------------------------------------------------------------------
// i2c_poll_scheduler_poll_timer
// Free-running poll period counter, 0..POLL_CNT-1, with a one-cycle tick while
// the counter sits on its last value (i.e. on the cycle before it wraps).
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   tick     one-cycle pulse once per POLL_CNT cycles
// -----------------------------------------------------------------------------
module i2c_poll_scheduler_poll_timer #(
   parameter int POLL_CNT = 5_000_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CW = (POLL_CNT > 1) ? $clog2(POLL_CNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(POLL_CNT - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Combinational so the FSM launches on the wrap edge: the first START
   // command is presented exactly POLL_CNT cycles after reset release.
   assign tick = (count_reg == LAST);

endmodule

// File: rtl/i2c_poll_scheduler.sv
// -----------------------------------------------------------------------------
// i2c_poll_scheduler
// Periodically reads a 16-bit register from an I2C device through the shared
// byte-level engine: START, addr+W, reg, RSTART, addr+R, MSB, LSB, STOP.
// A NACK on any address/register write ends the attempt with a STOP and the
// whole transaction is retried up to MAX_RETRY times before error is raised.
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake to the byte engine
//   cmd_op, cmd_wdata      command opcode and write byte (zero unless WRITE)
//   rsp_valid              completion pulse for the outstanding command
//   rsp_rdata, rsp_nack    read byte / write NACK, qualified by rsp_valid
//   data, data_valid       last good {MSB,LSB} result and its update pulse
//   error                  sticky retries-exhausted flag, cleared by a good read
//   busy                   a transaction is in progress
// -----------------------------------------------------------------------------
module i2c_poll_scheduler
   import i2c_poll_scheduler_pkg::*;
#(
   parameter int         CLK_HZ    = 50_000_000,
   parameter int         POLL_HZ   = 10,
   parameter logic [6:0] DEV_ADDR  = 7'h48,
   parameter logic [7:0] REG_ADDR  = 8'h00,
   parameter int         MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_op,
   output logic [7:0]  cmd_wdata,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_rdata,
   input  logic        rsp_nack,
   output logic [15:0] data,
   output logic        data_valid,
   output logic        error,
   output logic        busy
);

   localparam int         POLL_CNT    = CLK_HZ / POLL_HZ;
   localparam logic [2:0] MAX_RETRY_W = 3'(MAX_RETRY);

   logic tick;

   i2c_poll_scheduler_poll_timer #(.POLL_CNT(POLL_CNT)) u_poll_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   state_t      state_reg,      state_next;
   logic        cmd_valid_reg,  cmd_valid_next;
   logic [2:0]  cmd_op_reg,     cmd_op_next;
   logic [7:0]  cmd_wdata_reg,  cmd_wdata_next;
   logic        pending_reg,    pending_next;   // command accepted, awaiting rsp
   logic [2:0]  retry_reg,      retry_next;
   logic [7:0]  msb_reg,        msb_next;
   logic [7:0]  lsb_reg,        lsb_next;
   logic [15:0] data_reg,       data_next;
   logic        data_valid_reg, data_valid_next;
   logic        error_reg,      error_next;
   cmd_t        launch_cmd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         cmd_valid_reg  <= 1'b0;
         cmd_op_reg     <= 3'd0;
         cmd_wdata_reg  <= 8'h00;
         pending_reg    <= 1'b0;
         retry_reg      <= 3'd0;
         msb_reg        <= 8'h00;
         lsb_reg        <= 8'h00;
         data_reg       <= 16'h0000;
         data_valid_reg <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cmd_valid_reg  <= cmd_valid_next;
         cmd_op_reg     <= cmd_op_next;
         cmd_wdata_reg  <= cmd_wdata_next;
         pending_reg    <= pending_next;
         retry_reg      <= retry_next;
         msb_reg        <= msb_next;
         lsb_reg        <= lsb_next;
         data_reg       <= data_next;
         data_valid_reg <= data_valid_next;
         error_reg      <= error_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cmd_valid_next  = cmd_valid_reg;
      cmd_op_next     = cmd_op_reg;
      cmd_wdata_next  = cmd_wdata_reg;
      pending_next    = pending_reg;
      retry_next      = retry_reg;
      msb_next        = msb_reg;
      lsb_next        = lsb_reg;
      data_next       = data_reg;
      data_valid_next = 1'b0;
      error_next      = error_reg;
      launch_cmd      = '0;

      if (state_reg == ST_IDLE) begin
         // Ticks arriving while busy never reach here, so they are dropped.
         if (tick) begin
            state_next = ST_START;
         end
      end else if (cmd_valid_reg) begin
         if (cmd_ready) begin
            cmd_valid_next = 1'b0;
            pending_next   = 1'b1;
         end
      end else if (pending_reg && rsp_valid) begin
         pending_next = 1'b0;
         case (state_reg)
            ST_START:    state_next = ST_ADDR_W;
            ST_ADDR_W:   state_next = rsp_nack ? ST_STOP_ERR : ST_REG;
            ST_REG:      state_next = rsp_nack ? ST_STOP_ERR : ST_RSTART;
            ST_RSTART:   state_next = ST_ADDR_R;
            ST_ADDR_R:   state_next = rsp_nack ? ST_STOP_ERR : ST_READ_MSB;
            ST_READ_MSB: begin
               msb_next   = rsp_rdata;
               state_next = ST_READ_LSB;
            end
            ST_READ_LSB: begin
               lsb_next   = rsp_rdata;
               state_next = ST_STOP;
            end
            ST_STOP: begin
               data_next       = {msb_reg, lsb_reg};
               data_valid_next = 1'b1;
               error_next      = 1'b0;
               retry_next      = 3'd0;
               state_next      = ST_IDLE;
            end
            ST_STOP_ERR: begin
               // The count of attempts already retried decides; the first
               // failure sees retry_reg == 0.
               if (retry_reg < MAX_RETRY_W) begin
                  retry_next = retry_reg + 3'd1;
                  state_next = ST_START;
               end else begin
                  retry_next = 3'd0;
                  error_next = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end

      // Entering any command state presents that state's command next cycle.
      if ((state_next != state_reg) && (state_next != ST_IDLE)) begin
         launch_cmd     = cmd_for_state(state_next, DEV_ADDR, REG_ADDR);
         cmd_valid_next = 1'b1;
         cmd_op_next    = launch_cmd.op;
         cmd_wdata_next = launch_cmd.wdata;
      end
   end

   assign cmd_valid  = cmd_valid_reg;
   assign cmd_op     = cmd_op_reg;
   assign cmd_wdata  = cmd_wdata_reg;
   assign data       = data_reg;
   assign data_valid = data_valid_reg;
   assign error      = error_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_i2c_poll_scheduler
// Directed bench for i2c_poll_scheduler (POLL_CNT = 10). Expected commands and
// results are queued as each scenario is set up; a byte-engine responder pops
// them one command at a time and compares what the scheduler presents.
// -----------------------------------------------------------------------------
module tb_i2c_poll_scheduler;

   localparam int POLL = 10;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_nack;
   logic [15:0] data;
   logic        data_valid;
   logic        error;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc;
   logic [15:0] exp_data;

   // kind: 0 ordinary command, 1 STOP of good read, 2 STOP before a retry,
   //       3 STOP after retries exhausted
   typedef struct {
      logic [2:0]  op;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        nack;
      bit          tick;
      int          hold;
      int          kind;
      logic [15:0] dat;
   } step_t;

   step_t exp_q[$];

   i2c_poll_scheduler #(
      .CLK_HZ    (1000),
      .POLL_HZ   (100),
      .DEV_ADDR  (7'h48),
      .REG_ADDR  (8'h00),
      .MAX_RETRY (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_nack   (rsp_nack),
      .data       (data),
      .data_valid (data_valid),
      .error      (error),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release; tracks the scheduler's free-running timer.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] wd, input logic [7:0] rd,
                       input logic nk, input bit tk, input int hold, input int kind);
      step_t s;
      s.op = op; s.wdata = wd; s.rdata = rd; s.nack = nk;
      s.tick = tk; s.hold = hold; s.kind = kind; s.dat = exp_data;
      exp_q.push_back(s);
   endtask

   task automatic push_good(input logic [7:0] msb, input logic [7:0] lsb,
                            input bit tk, input int rs_hold);
      push(3'd0, 8'h00, 8'h00, 1'b0, tk, 0, 0);
      push(3'd2, 8'h90, 8'h00, 1'b0, 0, 0, 0);
      push(3'd2, 8'h00, 8'h00, 1'b0, 0, 0, 0);
      push(3'd1, 8'h00, 8'h00, 1'b0, 0, rs_hold, 0);
      push(3'd2, 8'h91, 8'h00, 1'b0, 0, 0, 0);
      push(3'd3, 8'h00, msb,   1'b0, 0, 0, 0);
      push(3'd4, 8'h00, lsb,   1'b0, 0, 0, 0);
      exp_data = {msb, lsb};
      push(3'd5, 8'h00, 8'h00, 1'b0, 0, 0, 1);
   endtask

   // at: 1 = NACK on addr+W, 2 = NACK on register byte
   task automatic push_fail(input int at, input bit tk, input bit last);
      push(3'd0, 8'h00, 8'h00, 1'b0, tk, 0, 0);
      push(3'd2, 8'h90, 8'h00, (at == 1), 0, 0, 0);
      if (at == 2) push(3'd2, 8'h00, 8'h00, 1'b1, 0, 0, 0);
      push(3'd5, 8'h00, 8'h00, 1'b0, 0, 0, last ? 3 : 2);
   endtask

   // Act as the byte engine for one expected command.
   task automatic serve();
      step_t e;
      int w;
      e = exp_q.pop_front();
      w = 0;
      while (cmd_valid !== 1'b1 && w < 30) begin
         @(negedge clk);
         w++;
      end
      check("cmd_valid", cmd_valid, 1);
      check("cmd_op", cmd_op, e.op);
      check("cmd_wdata", cmd_wdata, e.wdata);
      if (e.tick) check("start_on_tick", cyc % POLL, 0);
      for (int i = 0; i < e.hold; i++) begin
         @(negedge clk);
         check("stall_valid", cmd_valid, 1);
         check("stall_op", cmd_op, e.op);
         check("stall_wdata", cmd_wdata, e.wdata);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("one_outstanding", cmd_valid, 0);
      rsp_valid = 1'b1;
      rsp_rdata = e.rdata;
      rsp_nack  = e.nack;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      rsp_nack  = 1'b0;
      $display("txn op=%0d wdata=%02h rdata=%02h nack=%0d cycle=%0d",
               e.op, e.wdata, e.rdata, e.nack, cyc);
      if (e.kind != 0) begin
         check("data_valid", data_valid, (e.kind == 1));
         check("data", data, e.dat);
         check("error", error, (e.kind == 3));
         check("busy", busy, (e.kind == 2));
         if (e.kind == 1) begin
            @(negedge clk);
            check("data_valid_pulse", data_valid, 0);
            check("data_hold", data, e.dat);
         end
      end
   endtask

   task automatic run_all();
      while (exp_q.size() > 0) serve();
   endtask

   // Called at the negedge where reset is released.
   task automatic expect_first_start();
      for (int i = 1; i < POLL; i++) begin
         @(negedge clk);
         check("pre_valid", cmd_valid, 0);
         check("pre_busy", busy, 0);
         check("pre_op", cmd_op, 0);
         check("pre_dv", data_valid, 0);
      end
      @(negedge clk);
      check("first_start_cycle", cyc, POLL);
      check("first_start_valid", cmd_valid, 1);
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", cmd_valid, 0);
      check("rst_op", cmd_op, 0);
      check("rst_wdata", cmd_wdata, 0);
      check("rst_data", data, 0);
      check("rst_dv", data_valid, 0);
      check("rst_error", error, 0);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      rsp_nack  = 1'b0;
      exp_data  = 16'h0000;

      // 1: reset values, first START exactly POLL_CNT cycles after release
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset_n = 1'b1;
      expect_first_start();

      // 2: good read
      push_good(8'h1A, 8'h2B, 1, 0);
      run_all();

      // 3: NACK on addr+W twice, then success
      push_fail(1, 1, 0);
      push_fail(1, 0, 0);
      push_good(8'hC3, 8'hD4, 0, 0);
      run_all();

      // 4: NACK on register byte four times, retries exhausted
      push_fail(2, 1, 0);
      push_fail(2, 0, 0);
      push_fail(2, 0, 0);
      push_fail(2, 0, 1);
      run_all();
      @(negedge clk);
      check("error_sticky", error, 1);

      // 5: engine stalls on RSTART across a tick; good read clears error
      push_good(8'h5E, 8'h6F, 1, 20);
      run_all();

      // 6: reset during the MSB read
      push_good(8'h77, 8'h88, 1, 0);
      repeat (5) serve();
      check("rm_valid", cmd_valid, 1);
      check("rm_op", cmd_op, 3);
      #1 reset_n = 1'b0;
      #1 check_reset_outputs();
      exp_q.delete();
      exp_data = 16'h0000;
      @(negedge clk);
      reset_n = 1'b1;
      expect_first_start();
      push_good(8'h99, 8'hAA, 1, 0);
      run_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
